// File: rtl/rubik_wr_seq.sv
// Rubik write-command sequencer: pops write commands and expands each into
// DMA write requests of at most MAX_BURST 32-byte atoms with line/surface stepping.
module rubik_wr_seq #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        autosa_core_clk,
    input  logic        autosa_core_rstn,
    input  logic        wcmd_pvld,
    output logic        wcmd_prdy,
    input  logic [10:0] wcmd_pd,
    input  logic        reg2dp_op_en,
    input  logic [31:0] reg2dp_dst_base_addr,
    input  logic [31:0] reg2dp_dst_line_stride,
    input  logic [31:0] reg2dp_dst_surf_stride,
    output logic        dma_wr_req_pvld,
    input  logic        dma_wr_req_prdy,
    output logic [31:0] dma_wr_req_addr,
    output logic [2:0]  dma_wr_req_size,
    output logic        wr_done,
    output logic [31:0] wr_req_cnt
);

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned REM_W      = 9;
    localparam int unsigned SIZE_W     = 3;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned ATOM_SHIFT = 5;

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(32'h1F);
    localparam logic [REM_W-1:0]  BURST     = REM_W'(MAX_BURST);

    typedef struct packed {
        logic             layer_end;
        logic             surf_end;
        logic             line_end;
        logic [LEN_W-1:0] len_m1;
    } wcmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CMD = 2'd1,
        ISSUE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] surf_ptr_q, surf_ptr_nxt;
    logic [ADDR_W-1:0] line_ptr_q, line_ptr_nxt;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_nxt;
    logic [REM_W-1:0]  remain_q, remain_nxt;
    logic              line_end_q, line_end_nxt;
    logic              surf_end_q, surf_end_nxt;
    logic              layer_end_q, layer_end_nxt;
    logic [ADDR_W-1:0] req_cnt_q, req_cnt_nxt;
    logic              wcmd_prdy_q, pvld_q, done_q;
    logic [SIZE_W-1:0] size_q, size_nxt;

    wcmd_t             cmd;
    logic [REM_W-1:0]  chunk;
    logic [REM_W-1:0]  remain_left;
    logic [ADDR_W-1:0] adv_addr;
    logic [ADDR_W-1:0] base_aligned;
    logic [ADDR_W-1:0] surf_step;
    logic [ADDR_W-1:0] line_step;

    function automatic logic [REM_W-1:0] chunk_of(input logic [REM_W-1:0] rem);
        return (rem > BURST) ? BURST : rem;
    endfunction

    assign cmd          = wcmd_t'(wcmd_pd);
    assign chunk        = chunk_of(remain_q);
    assign remain_left  = remain_q - chunk;
    assign adv_addr     = cur_addr_q + (ADDR_W'(chunk) << ATOM_SHIFT);
    assign base_aligned = reg2dp_dst_base_addr & ADDR_MASK;
    assign surf_step    = (surf_ptr_q + reg2dp_dst_surf_stride) & ADDR_MASK;
    assign line_step    = (line_ptr_q + reg2dp_dst_line_stride) & ADDR_MASK;

    // Next-state and datapath updates
    always_comb begin
        state_nxt     = state_q;
        surf_ptr_nxt  = surf_ptr_q;
        line_ptr_nxt  = line_ptr_q;
        cur_addr_nxt  = cur_addr_q;
        remain_nxt    = remain_q;
        line_end_nxt  = line_end_q;
        surf_end_nxt  = surf_end_q;
        layer_end_nxt = layer_end_q;
        req_cnt_nxt   = req_cnt_q;
        size_nxt      = '0;

        case (state_q)
            IDLE: begin
                if (reg2dp_op_en) begin
                    surf_ptr_nxt = base_aligned;
                    line_ptr_nxt = base_aligned;
                    cur_addr_nxt = base_aligned;
                    req_cnt_nxt  = '0;
                    state_nxt    = WAIT_CMD;
                end
            end
            WAIT_CMD: begin
                if (wcmd_pvld) begin
                    remain_nxt    = REM_W'(cmd.len_m1) + REM_W'(1);
                    line_end_nxt  = cmd.line_end;
                    surf_end_nxt  = cmd.surf_end;
                    layer_end_nxt = cmd.layer_end;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (dma_wr_req_prdy) begin
                    remain_nxt   = remain_left;
                    req_cnt_nxt  = req_cnt_q + ADDR_W'(1);
                    cur_addr_nxt = adv_addr;
                    if (remain_left == '0) begin
                        // surface step dominates line step
                        if (surf_end_q) begin
                            surf_ptr_nxt = surf_step;
                            line_ptr_nxt = surf_step;
                            cur_addr_nxt = surf_step;
                        end else if (line_end_q) begin
                            line_ptr_nxt = line_step;
                            cur_addr_nxt = line_step;
                        end
                        state_nxt = layer_end_q ? DONE : WAIT_CMD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == ISSUE) begin
            size_nxt = SIZE_W'(chunk_of(remain_nxt) - REM_W'(1));
        end
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state_q     <= IDLE;
            surf_ptr_q  <= '0;
            line_ptr_q  <= '0;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            line_end_q  <= 1'b0;
            surf_end_q  <= 1'b0;
            layer_end_q <= 1'b0;
            req_cnt_q   <= '0;
            wcmd_prdy_q <= 1'b0;
            pvld_q      <= 1'b0;
            done_q      <= 1'b0;
            size_q      <= '0;
        end else begin
            state_q     <= state_nxt;
            surf_ptr_q  <= surf_ptr_nxt;
            line_ptr_q  <= line_ptr_nxt;
            cur_addr_q  <= cur_addr_nxt;
            remain_q    <= remain_nxt;
            line_end_q  <= line_end_nxt;
            surf_end_q  <= surf_end_nxt;
            layer_end_q <= layer_end_nxt;
            req_cnt_q   <= req_cnt_nxt;
            wcmd_prdy_q <= (state_nxt == WAIT_CMD);
            pvld_q      <= (state_nxt == ISSUE);
            done_q      <= (state_nxt == DONE);
            size_q      <= size_nxt;
        end
    end

    assign wcmd_prdy       = wcmd_prdy_q;
    assign dma_wr_req_pvld = pvld_q;
    assign dma_wr_req_addr = cur_addr_q;
    assign dma_wr_req_size = size_q;
    assign wr_done         = done_q;
    assign wr_req_cnt      = req_cnt_q;

endmodule
